sm_lsu: RTL
===========

Name: sm_lsu

Overview:
Parametrised load/store unit between the schoolMIPS core and the data-memory bus. It replaces the fixed word-only memory hazard logic with a real FSM. The FSM issues one registered request per memory instruction, stalls the core until the bus responds, and returns sized, lane-aligned, optionally sign-extended load data. It also flags misaligned accesses and, as an option, bus timeouts, so the core can raise exceptions.

Parameters:
DATA_WIDTH, 32, bus data width; legal values 32 or 64.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_W, 8, timeout counter width; bus error after 2^TIMEOUT_W-1 WAIT cycles. Used only with SM_LSU_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lsuReq  in  1  memory instruction in execute; held high while lsuStall=1
lsuWe  in  1  1=store, 0=load
lsuSize  in  2  00 byte, 01 half, 10 word, 11 dword (64-bit only)
lsuSigned  in  1  sign-extend load result
lsuAddr  in  ADDR_WIDTH  byte address
lsuWData  in  DATA_WIDTH  store data, right-aligned
lsuStall  out  1  hold PC/pipeline
lsuRData  out  DATA_WIDTH  load result, valid in DONE
lsuAddrErr  out  1  one-cycle misaligned/illegal-size pulse
lsuBusErr  out  1  timeout flag, valid in DONE
dmAddr  out  ADDR_WIDTH  registered address, lane bits cleared
dmWe  out  1  registered write enable
dmBe  out  DATA_WIDTH/8  registered byte enables
dmWData  out  DATA_WIDTH  registered write data, replicated to all lanes
dmValid  out  1  request strobe, exactly one cycle per access
dmReady  in  1  response; sampled only in REQ/WAIT
dmRData  in  DATA_WIDTH  read data, valid with dmReady

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE. dmValid, dmWe, dmBe, lsuAddrErr and lsuBusErr are 0. dmAddr, dmWData and the load-capture register are 0. Reset mid-access abandons it with no further dmValid.
- L = log2(DATA_WIDTH/8). lane = lsuAddr[L-1:0].
- Misaligned conditions: half with lane[0]≠0; word with lane[1:0]≠0; dword with lane≠0; dword when DATA_WIDTH=32.
- IDLE:
  - lsuReq=1 and misaligned: lsuAddrErr=1 combinationally. lsuStall=0, no bus request, stay IDLE.
  - lsuReq=1 and aligned: lsuStall=1. Register dmAddr (lane bits zero), dmWe, dmBe, dmWData, size, signed and lane. Go to REQ.
- REQ: dmValid=1 for this cycle only, lsuStall=1.
  - dmReady=1: capture dmRData, go to DONE (zero-wait bus).
  - Otherwise: clear the timeout counter, go to WAIT.
- WAIT: dmValid=0, lsuStall=1.
  - dmReady=1: capture dmRData, go to DONE.
  - Each cycle otherwise: counter+1.
- DONE: lsuStall=0 and lsuRData valid. Always go to IDLE next cycle, regardless of lsuReq. Back-to-back memory instructions therefore each cost 2 minimum stall cycles.
- dmBe: byte→1<<lane; half→3<<lane; word→4'hF<<lane; dword→all ones. Store data replicated by size across the bus.
- Load extraction: shift the captured data right by lane*8, then mask to the size. With lsuSigned, sign-extend from bit 7/15/31; without it, zero-extend. Stores drive lsuRData=0.
- dmReady in IDLE or DONE is ignored.
- lsuStall = lsuReq & state≠DONE & ~(state==IDLE & misaligned).

Optional Feature:
SM_LSU_TIMEOUT_EN
- Defined: in WAIT, when the counter reaches 2^TIMEOUT_W-1 with no dmReady, go to DONE with lsuBusErr=1 and lsuRData=0. lsuBusErr clears on leaving DONE. The bus must not respond after a timeout; a late dmReady arriving in IDLE/DONE is ignored.
- Undefined: no counter; WAIT lasts until dmReady; lsuBusErr tied 0.

Test Plan:
- Zero-wait word load: lsuAddr=0x10, size=10, dmReady=1 in REQ, dmRData=0xDEADBEEF → dmValid high exactly 1 cycle, dmBe=4'hF, 2 stall cycles, lsuRData=0xDEADBEEF in DONE.
- Signed byte load with 3 wait cycles: addr=0x13, dmRData=0x80112233 → dmBe=4'b1000, stall 5 cycles, lsuRData=0xFFFFFF80; same with lsuSigned=0 → 0x00000080.
- Half store: addr=0x22, lsuWData=0x0000ABCD → dmWe=1, dmBe=4'b1100, dmWData=0xABCDABCD, dmAddr=0x20.
- Misaligned word load at 0x21 → lsuAddrErr pulse 1 cycle, lsuStall=0, no dmValid; dword access at DATA_WIDTH=32 → same.
- Timeout (macro on, TIMEOUT_W=3): dmReady held 0 → DONE after 7 WAIT cycles with lsuBusErr=1, lsuRData=0; macro off → stall persists 20+ cycles until dmReady.
- Reset asserted in WAIT → all outputs 0 immediately; after release, a new request issues a single dmValid.

Source files
------------

// File: rtl/sm_lsu.sv
// sm_lsu: load/store unit FSM between the schoolMIPS core and the data-memory bus.
// Optional bus-timeout detection is enabled with `define SM_LSU_TIMEOUT_EN.
module sm_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lsuReq,
    input  logic                      lsuWe,
    input  logic [1:0]                lsuSize,
    input  logic                      lsuSigned,
    input  logic [ADDR_WIDTH-1:0]     lsuAddr,
    input  logic [DATA_WIDTH-1:0]     lsuWData,
    output logic                      lsuStall,
    output logic [DATA_WIDTH-1:0]     lsuRData,
    output logic                      lsuAddrErr,
    output logic                      lsuBusErr,
    output logic [ADDR_WIDTH-1:0]     dmAddr,
    output logic                      dmWe,
    output logic [DATA_WIDTH/8-1:0]   dmBe,
    output logic [DATA_WIDTH-1:0]     dmWData,
    output logic                      dmValid,
    input  logic                      dmReady,
    input  logic [DATA_WIDTH-1:0]     dmRData
);

    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned L  = $clog2(BW);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_W < 1) begin : g_param_check
        $error("sm_lsu: unsupported DATA_WIDTH or TIMEOUT_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;

    logic [L-1:0]          w_lane;
    logic                  w_misalign;
    logic [BW-1:0]         w_be_mask;
    logic [BW-1:0]         w_be;
    logic [DATA_WIDTH-1:0] w_wdata_rep;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_timeout;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [BW-1:0]         r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [L-1:0]          r_lane;
    logic [DATA_WIDTH-1:0] r_cap;

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [31:0]           w_nbits;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_lane = lsuAddr[L-1:0];

    always_comb begin
        case (lsuSize)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_lane[0];
            2'b10:   w_misalign = (w_lane[1:0] != 2'b00);
            default: w_misalign = (DATA_WIDTH == 32) || (w_lane != '0);
        endcase
    end

    always_comb begin
        case (lsuSize)
            2'b00:   w_be_mask = BW'(1);
            2'b01:   w_be_mask = BW'(3);
            2'b10:   w_be_mask = BW'(15);
            default: w_be_mask = '1;
        endcase
    end

    assign w_be = w_be_mask << w_lane;

    // Each byte lane takes the store byte at its offset within the access size.
    always_comb begin
        w_wdata_rep = '0;
        for (int unsigned i = 0; i < BW; i++) begin
            case (lsuSize)
                2'b00:   w_wdata_rep[i*8 +: 8] = lsuWData[7:0];
                2'b01:   w_wdata_rep[i*8 +: 8] = lsuWData[(i%2)*8 +: 8];
                2'b10:   w_wdata_rep[i*8 +: 8] = lsuWData[(i%4)*8 +: 8];
                default: w_wdata_rep[i*8 +: 8] = lsuWData[i*8 +: 8];
            endcase
        end
    end

    assign w_accept  = lsuReq && (r_state == S_IDLE) && !w_misalign;
    assign w_capture = ((r_state == S_REQ) || (r_state == S_WAIT)) && dmReady;

`ifdef SM_LSU_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [TIMEOUT_W-1:0] w_cnt_inc;
    logic                 r_buserr;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Fires in the WAIT cycle whose increment would reach the all-ones limit.
    assign w_timeout = (r_state == S_WAIT) && !dmReady && (w_cnt_inc == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_buserr <= 1'b0;
        end else begin
            if (r_state == S_REQ)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= w_cnt_inc;
            if (w_timeout)
                r_buserr <= 1'b1;
            else if (r_state == S_DONE)
                r_buserr <= 1'b0;
        end
    end

    assign lsuBusErr = r_buserr;
`else
    assign w_timeout = 1'b0;
    assign lsuBusErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (lsuReq && !w_misalign) w_next = S_REQ;
            S_REQ:   w_next = dmReady ? S_DONE : S_WAIT;
            S_WAIT:  if (dmReady || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dmValid    = (r_state == S_REQ);
        lsuAddrErr = lsuReq && (r_state == S_IDLE) && w_misalign;
        lsuStall   = lsuReq && (r_state != S_DONE) && !((r_state == S_IDLE) && w_misalign);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_lane   <= '0;
            r_cap    <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= {lsuAddr[ADDR_WIDTH-1:L], {L{1'b0}}};
                r_we     <= lsuWe;
                r_be     <= w_be;
                r_wdata  <= w_wdata_rep;
                r_size   <= lsuSize;
                r_signed <= lsuSigned;
                r_lane   <= w_lane;
            end
            if (w_capture)
                r_cap <= dmRData;
            else if (w_timeout)
                r_cap <= '0;
        end
    end

    assign dmAddr  = r_addr;
    assign dmWe    = r_we;
    assign dmBe    = r_be;
    assign dmWData = r_wdata;

    assign w_shifted = r_cap >> {r_lane, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   begin w_nbits = 32'd8;  w_sign = w_shifted[7];  end
            2'b01:   begin w_nbits = 32'd16; w_sign = w_shifted[15]; end
            2'b10:   begin w_nbits = 32'd32; w_sign = w_shifted[31]; end
            default: begin w_nbits = DATA_WIDTH; w_sign = 1'b0; end
        endcase
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++)
            w_rdata[i] = (i < w_nbits) ? w_shifted[i] : (r_signed && w_sign);
    end

    assign lsuRData = r_we ? '0 : w_rdata;

endmodule
